// File: rtl/uart_rx_fifo_ctrl_if.sv
// Bundle of receiver-side and host-side signals for uart_rx_fifo_ctrl.
// The master modport is the environment (receiver plus APB register file).
// The slave modport is the FIFO controller itself.
interface uart_rx_fifo_ctrl_if #(
  parameter int AW     = 4,
  parameter int DATA_W = 8
);
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_read_clr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_status;
  logic              rd_valid;
  logic [AW:0]       thresh;
  logic              clr_overflow;
  logic [AW:0]       fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;
  logic              irq;

  modport master (
    output rx_ready, rx_data, rx_parity_err, rx_frame_err, rd_en, thresh, clr_overflow,
    input  rx_read_clr, rd_data, rd_status, rd_valid, fifo_count, fifo_empty, fifo_full,
           overflow, irq
  );

  modport slave (
    input  rx_ready, rx_data, rx_parity_err, rx_frame_err, rd_en, thresh, clr_overflow,
    output rx_read_clr, rd_data, rd_status, rd_valid, fifo_count, fifo_empty, fifo_full,
           overflow, irq
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: captures each received character with its
// parity/framing status into a circular FIFO, releases the receiver, serves
// host pops and raises overflow/threshold interrupts.
// Optional feature macro RX_TIMEOUT_EN adds baud_tick/timeout ports and an
// idle-character timeout term in irq.
module uart_rx_fifo_ctrl #(
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                reset_n,
  uart_rx_fifo_ctrl_if.slave bus
`ifdef RX_TIMEOUT_EN
  ,input  logic              baud_tick
  ,output logic              timeout
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int EW    = DATA_W + 2;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_CLR} state_t;

  state_t            state;
  state_t            next_state;
  logic              capture;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [EW-1:0]     mem [DEPTH];
  logic              empty;
  logic              full;
  logic              pop;
  logic              space;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_status_q;
  logic              rd_valid_q;
  logic              overflow_q;
  logic              thresh_hit;
  logic              timeout_term;

  assign empty = (count == '0);
  assign full  = (count == FULL_LEVEL);
  assign pop   = bus.rd_en & ~empty;
  // A pop in the capture cycle frees the slot the new character needs.
  assign space = ~full | pop;
  assign push  = capture & space;
  assign drop  = capture & ~space;

  // Capture sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Capture sequencer: take one character, release the receiver, wait for it to drop ready.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    unique case (state)
      IDLE:     if (bus.rx_ready) next_state = CAPTURE;
      CAPTURE:  begin
        capture    = 1'b1;
        next_state = WAIT_CLR;
      end
      WAIT_CLR: if (!bus.rx_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.rx_frame_err, bus.rx_parity_err, bus.rx_data};
  end

  // Pointers, occupancy, registered pop data and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_data_q   <= '0;
      rd_status_q <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        rd_data_q   <= mem[rd_ptr][DATA_W-1:0];
        rd_status_q <= mem[rd_ptr][DATA_W+1:DATA_W];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_TICKS = 10'd640;

  logic [9:0] idle_ticks;
  logic       timeout_q;
  logic       advance;

  assign advance = baud_tick & ~empty & (state == IDLE);

  // Idle timer: counts baud ticks while data sits unread and no character is arriving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_ticks <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (push | pop)                              idle_ticks <= '0;
      else if (advance && idle_ticks != TIMEOUT_TICKS) idle_ticks <= idle_ticks + 1'b1;
      if (pop | empty)                             timeout_q <= 1'b0;
      else if (advance && idle_ticks == TIMEOUT_TICKS - 10'd1) timeout_q <= 1'b1;
    end
  end

  assign timeout      = timeout_q;
  assign timeout_term = timeout_q;
`else
  assign timeout_term = 1'b0;
`endif

  assign thresh_hit = (bus.thresh != '0) && (count >= bus.thresh);

  assign bus.rx_read_clr = capture;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_status   = rd_status_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.fifo_count  = count;
  assign bus.fifo_empty  = empty;
  assign bus.fifo_full   = full;
  assign bus.overflow    = overflow_q;
  assign bus.irq         = thresh_hit | overflow_q | timeout_term;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Testbench for uart_rx_fifo_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

`ifdef RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic timeout;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic baud_tick;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo_ctrl_if #(.AW(AW), .DATA_W(DW)) bus ();

  uart_rx_fifo_ctrl #(.AW(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus)
`ifdef RX_TIMEOUT_EN
    ,.baud_tick(baud_tick)
    ,.timeout  (timeout)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model state: FIFO contents as a queue plus handshake flags
  logic [DW+1:0] m_q[$];
  logic [DW+1:0] m_entry;
  logic [DW-1:0] m_rd_data;
  logic [1:0]    m_rd_status;
  bit            m_rd_valid, m_ovf, m_tmo, m_pending, m_taken;
  int            m_ticks;
  int            size0;
  bit            was_idle, do_pop, do_push, dropped, tmo_hit;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model update: what the spec says happens at each rising edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_rd_data   = '0;
      m_rd_status = '0;
      m_rd_valid  = 0;
      m_ovf       = 0;
      m_tmo       = 0;
      m_pending   = 0;
      m_taken     = 0;
      m_ticks     = 0;
    end else begin
      size0    = m_q.size();
      was_idle = !m_pending && !m_taken;
      do_pop   = bus.rd_en && (size0 != 0);
      do_push  = 0;
      dropped  = 0;
      m_rd_valid = do_pop;
      if (do_pop) begin
        m_entry     = m_q.pop_front();
        m_rd_data   = m_entry[DW-1:0];
        m_rd_status = m_entry[DW+1:DW];
      end
      if (m_pending) begin
        if (size0 < DEPTH || do_pop) begin
          m_q.push_back({bus.rx_frame_err, bus.rx_parity_err, bus.rx_data});
          do_push = 1;
        end else begin
          dropped = 1;
        end
      end
      if (dropped) m_ovf = 1;
      else if (bus.clr_overflow) m_ovf = 0;
      tmo_hit = 0;
      if (do_push || do_pop) m_ticks = 0;
      else if (baud_tick && size0 != 0 && was_idle && m_ticks < 640) begin
        m_ticks++;
        tmo_hit = (m_ticks == 640);
      end
      if (do_pop || size0 == 0) m_tmo = 0;
      else if (tmo_hit && TMO_EN) m_tmo = 1;
      if (m_pending) m_taken = 1;
      else if (m_taken && !bus.rx_ready) m_taken = 0;
      m_pending = was_idle && bus.rx_ready;
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    if ($time > 2) begin
      checkOutput("fifo_count",  bus.fifo_count, m_q.size());
      checkOutput("fifo_empty",  bus.fifo_empty, m_q.size() == 0);
      checkOutput("fifo_full",   bus.fifo_full,  m_q.size() == DEPTH);
      checkOutput("overflow",    bus.overflow,   m_ovf);
      checkOutput("rx_read_clr", bus.rx_read_clr, m_pending);
      checkOutput("rd_valid",    bus.rd_valid,   m_rd_valid);
      checkOutput("rd_data",     bus.rd_data,    m_rd_data);
      checkOutput("rd_status",   bus.rd_status,  m_rd_status);
      checkOutput("irq", bus.irq,
                  ((bus.thresh != 0) && (m_q.size() >= int'(bus.thresh))) || m_ovf || m_tmo);
`ifdef RX_TIMEOUT_EN
      checkOutput("timeout", timeout, m_tmo);
`endif
    end
  end

  // One receiver character: raise ready, optional pop/clear in the capture cycle, then release
  task automatic applyStimulus(input logic [DW-1:0] data, input bit perr, input bit ferr,
                               input bit pop_in_capture, input bit clr_in_capture);
    bus.rx_ready      = 1'b1;
    bus.rx_data       = data;
    bus.rx_parity_err = perr;
    bus.rx_frame_err  = ferr;
    step(1);
    checkOutput("rx_read_clr_capture", bus.rx_read_clr, 1'b1);
    bus.rd_en        = pop_in_capture;
    bus.clr_overflow = clr_in_capture;
    step(1);
    bus.rd_en        = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.rx_ready     = 1'b0;
    step(1);
  endtask

  task automatic popOnce();
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    int pop_pct;
    bus.rx_ready = 0; bus.rx_data = 0; bus.rx_parity_err = 0; bus.rx_frame_err = 0;
    bus.rd_en = 0; bus.thresh = 0; bus.clr_overflow = 0; baud_tick = 0;
    #1 reset_n = 1'b0;
    step(2);
    checkOutput("reset_empty", bus.fifo_empty, 1'b1);
    checkOutput("reset_full",  bus.fifo_full,  1'b0);
    checkOutput("reset_irq",   bus.irq,        1'b0);
    checkOutput("reset_clr",   bus.rx_read_clr, 1'b0);
    reset_n = 1'b1;
    step(1);

    $display("[TB] single character");
    applyStimulus(8'hA5, 0, 0, 0, 0);
    checkOutput("t1_count", bus.fifo_count, 1);
    popOnce();
    checkOutput("t1_rd_valid",  bus.rd_valid,   1'b1);
    checkOutput("t1_rd_data",   bus.rd_data,    8'hA5);
    checkOutput("t1_rd_status", bus.rd_status,  2'b00);
    checkOutput("t1_empty",     bus.fifo_empty, 1'b1);

    $display("[TB] fill and overflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(i), 0, 0, 0, 0);
    checkOutput("t2_full", bus.fifo_full, 1'b1);
    applyStimulus(8'hFF, 0, 0, 0, 0);
    checkOutput("t2_overflow", bus.overflow,   1'b1);
    checkOutput("t2_count",    bus.fifo_count, DEPTH);
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1);
      checkOutput("t2_pop_order", bus.rd_data, i);
    end
    bus.rd_en = 1'b0;
    step(1);
    checkOutput("t2_empty_after", bus.fifo_empty, 1'b1);

    $display("[TB] full with simultaneous pop");
    bus.clr_overflow = 1'b1;
    step(1);
    bus.clr_overflow = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(8'h20 + i), 0, 0, 0, 0);
    applyStimulus(8'h3C, 0, 0, 1, 0);
    checkOutput("t3_overflow", bus.overflow,   1'b0);
    checkOutput("t3_count",    bus.fifo_count, DEPTH);
    bus.rd_en = 1'b1;
    step(DEPTH);
    bus.rd_en = 1'b0;
    checkOutput("t3_last_char", bus.rd_data, 8'h3C);

    $display("[TB] status and irq");
    resetDut();
    bus.thresh = 2;
    applyStimulus(8'h55, 1, 1, 0, 0);
    checkOutput("t4_irq_one", bus.irq, 1'b0);
    applyStimulus(8'h56, 0, 0, 0, 0);
    checkOutput("t4_irq_two", bus.irq, 1'b1);
    popOnce();
    checkOutput("t4_rd_data",   bus.rd_data,   8'h55);
    checkOutput("t4_rd_status", bus.rd_status, 2'b11);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(DW'(8'h60 + i), 0, 0, 0, 0);
    checkOutput("t4_full", bus.fifo_full, 1'b1);
    applyStimulus(8'h77, 0, 0, 0, 1);
    checkOutput("t4_set_wins", bus.overflow, 1'b1);
    bus.clr_overflow = 1'b1;
    step(1);
    bus.clr_overflow = 1'b0;
    checkOutput("t4_cleared", bus.overflow, 1'b0);

    $display("[TB] reset mid-operation");
    resetDut();
    bus.thresh = 1;
    applyStimulus(8'h01, 0, 0, 0, 0);
    applyStimulus(8'h02, 0, 0, 0, 0);
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h03;
    step(2);
    checkOutput("t5_count_pre", bus.fifo_count, 3);
    checkOutput("t5_irq_pre",   bus.irq,        1'b1);
    reset_n = 1'b0;
    step(1);
    checkOutput("t5_empty", bus.fifo_empty, 1'b1);
    checkOutput("t5_irq",   bus.irq,        1'b0);
    step(1);
    reset_n = 1'b1;
    bus.rx_data = 8'h44;
    step(2);
    bus.rx_ready = 1'b0;
    step(3);
    checkOutput("t5_one_capture", bus.fifo_count, 1);
    popOnce();
    checkOutput("t5_data", bus.rd_data, 8'h44);

    $display("[TB] idle timeout");
    resetDut();
    bus.thresh = 0;
    applyStimulus(8'h12, 0, 0, 0, 0);
    baud_tick = 1'b1;
    step(639);
`ifdef RX_TIMEOUT_EN
    checkOutput("t6_timeout_639", timeout, 1'b0);
`endif
    checkOutput("t6_irq_639", bus.irq, 1'b0);
    step(1);
    baud_tick = 1'b0;
`ifdef RX_TIMEOUT_EN
    checkOutput("t6_timeout_640", timeout, 1'b1);
    checkOutput("t6_irq_640",     bus.irq, 1'b1);
`else
    checkOutput("t6_irq_disabled", bus.irq, 1'b0);
`endif
    popOnce();
`ifdef RX_TIMEOUT_EN
    checkOutput("t6_timeout_pop", timeout, 1'b0);
`endif
    checkOutput("t6_irq_pop", bus.irq, 1'b0);

    $display("[TB] randomized traffic");
    resetDut();
    bus.thresh = 4'($urandom_range(0, DEPTH));
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 3);
      pop_pct = (n < 150) ? 25 : 70;
      for (int g = 0; g < gap; g++) begin
        bus.rd_en        = ($urandom_range(0, 99) < pop_pct);
        bus.clr_overflow = ($urandom_range(0, 15) == 0);
        baud_tick        = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 31) == 0) bus.thresh = (AW+1)'($urandom_range(0, DEPTH));
        step(1);
      end
      bus.rd_en = 0; bus.clr_overflow = 0; baud_tick = 0;
      applyStimulus(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < pop_pct), ($urandom_range(0, 7) == 0));
    end
    bus.rd_en = 1'b1;
    step(DEPTH + 2);
    bus.rd_en = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
